// File: rtl/nnrv_pkg.sv
// Shared pipeline definitions: op-type codes, default datapath width and
// the execute-stage FSM/shift-direction encodings used by decode and execute.
package nnrv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ex_state_t;

  typedef enum logic [1:0] {
    DIR_SLL = 2'd0,
    DIR_SRL = 2'd1,
    DIR_SRA = 2'd2
  } shift_dir_t;

  function automatic shift_dir_t op_to_dir(input logic [3:0] op);
    case (op)
      OP_SRL:  return DIR_SRL;
      OP_SRA:  return DIR_SRA;
      default: return DIR_SLL;
    endcase
  endfunction

endpackage

// File: rtl/nnrv_ex_shifter.sv
// Shift unit for the execute stage: iterative 1 bit/cycle by default, or a
// single-cycle barrel shifter when NNRV_EX_FAST_SHIFT_EN is defined.
module nnrv_ex_shifter
  import nnrv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               start,
  input  logic [XLEN-1:0]    op1,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_dir_t         dir,
  output logic               iterative,
  output logic [XLEN-1:0]    imm_result,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

`ifdef NNRV_EX_FAST_SHIFT_EN

  logic unused_ok;
  assign unused_ok = ^{start, i_clk, i_rst};

  always_comb begin
    imm_result = op1;
    case (dir)
      DIR_SLL: imm_result = op1 << shamt;
      DIR_SRL: imm_result = op1 >> shamt;
      DIR_SRA: imm_result = $unsigned($signed(op1) >>> shamt);
      default: imm_result = op1;
    endcase
  end

  assign iterative = 1'b0;
  assign busy      = 1'b0;
  assign done      = 1'b0;
  assign result    = '0;

`else

  ex_state_t          state;
  shift_dir_t         dir_q;
  logic [XLEN-1:0]    acc;
  logic [XLEN-1:0]    next_acc;
  logic [SHAMT_W-1:0] cnt;

  always_comb begin
    next_acc = acc;
    case (dir_q)
      DIR_SLL: next_acc = {acc[XLEN-2:0], 1'b0};
      DIR_SRL: next_acc = {1'b0, acc[XLEN-1:1]};
      DIR_SRA: next_acc = {acc[XLEN-1], acc[XLEN-1:1]};
      default: next_acc = acc;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      dir_q <= DIR_SLL;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= op1;
            cnt   <= shamt;
            dir_q <= dir;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= next_acc;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A zero shift amount needs no iteration and completes like an ALU op.
  assign iterative  = (shamt != '0);
  assign imm_result = op1;
  assign busy       = (state == SHIFT);
  assign done       = busy && (cnt == SHAMT_W'(1));
  assign result     = next_acc;

`endif

endmodule

// File: rtl/nnrv_ex.sv
// Execute stage: integer ALU with a one-cycle write-back pulse; shifts go to
// nnrv_ex_shifter (iterative, or single-cycle with NNRV_EX_FAST_SHIFT_EN).
module nnrv_ex
  import nnrv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_exec_op1,
  input  logic [XLEN-1:0] i_exec_op2,
  input  logic [3:0]      i_exec_type,
  input  logic [4:0]      i_exec_rd,
  output logic            o_ex_busy,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
);

  logic            is_shift;
  logic            sh_start;
  logic            sh_iterative;
  logic            sh_busy;
  logic            sh_done;
  logic [XLEN-1:0] sh_imm_result;
  logic [XLEN-1:0] sh_result;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [4:0]      rd_q;

  assign is_shift = (i_exec_type == OP_SLL) || (i_exec_type == OP_SRL) ||
                    (i_exec_type == OP_SRA);
  assign sh_start = !sh_busy && is_shift && sh_iterative;

  nnrv_ex_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .start      (sh_start),
    .op1        (i_exec_op1),
    .shamt      (i_exec_op2[SHAMT_W-1:0]),
    .dir        (op_to_dir(i_exec_type)),
    .iterative  (sh_iterative),
    .imm_result (sh_imm_result),
    .busy       (sh_busy),
    .done       (sh_done),
    .result     (sh_result)
  );

  always_comb begin
    res_valid = 1'b1;
    res_data  = '0;
    case (i_exec_type)
      OP_ADD:  res_data = i_exec_op1 + i_exec_op2;
      OP_SUB:  res_data = i_exec_op1 - i_exec_op2;
      OP_SLT:  res_data = XLEN'($signed(i_exec_op1) < $signed(i_exec_op2));
      OP_SLTU: res_data = XLEN'(i_exec_op1 < i_exec_op2);
      OP_XOR:  res_data = i_exec_op1 ^ i_exec_op2;
      OP_OR:   res_data = i_exec_op1 | i_exec_op2;
      OP_AND:  res_data = i_exec_op1 & i_exec_op2;
      OP_SLL, OP_SRL, OP_SRA: begin
        res_valid = !sh_iterative;
        res_data  = sh_imm_result;
      end
      default: res_valid = 1'b0;
    endcase
  end

  // x0 writes still execute; only the strobe is suppressed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_en   <= 1'b0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
      rd_q      <= '0;
    end else begin
      o_wb_en <= 1'b0;
      if (sh_done) begin
        o_wb_en   <= (rd_q != 5'd0);
        o_wb_rd   <= rd_q;
        o_wb_data <= sh_result;
      end else if (!sh_busy) begin
        if (res_valid) begin
          o_wb_en   <= (i_exec_rd != 5'd0);
          o_wb_rd   <= i_exec_rd;
          o_wb_data <= res_data;
        end else if (sh_start) begin
          rd_q <= i_exec_rd;
        end
      end
    end
  end

  assign o_ex_busy = sh_busy;

endmodule

// File: tb/tb_nnrv_ex.sv
// Self-checking bench for nnrv_ex: directed ALU/shift/no-write cases, mid-shift
// reset, back-to-back issue and random ops, with a write-back scoreboard.
module tb_nnrv_ex;
  import nnrv_pkg::*;

`ifdef NNRV_EX_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  typ = '0;
  logic [4:0]  rd  = '0;
  logic        o_ex_busy;
  logic        o_wb_en;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  bit          mon_en = 1'b0;

  always #5 i_clk = ~i_clk;

  nnrv_ex dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_exec_op1  (op1),
    .i_exec_op2  (op2),
    .i_exec_type (typ),
    .i_exec_rd   (rd),
    .o_ex_busy   (o_ex_busy),
    .o_wb_en     (o_wb_en),
    .o_wb_rd     (o_wb_rd),
    .o_wb_data   (o_wb_data)
  );

  // Scoreboard: every write-back pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    if (mon_en && !i_rst && o_wb_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write-back", o_wb_rd, o_wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_wb_rd, o_wb_data} !== mon_e)
          $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   o_wb_rd, o_wb_data, mon_e[36:32], mon_e[31:0]);
        else n_pass++;
      end
    end
  end

  function automatic logic [31:0] model(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (t)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLL:  return a << s;
      OP_SRL:  return a >> s;
      OP_SRA:  return $unsigned($signed(a) >>> s);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] t, input logic [31:0] b);
    if (!FAST && t >= OP_SLL && t <= OP_SRA && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issues one op, scribbles random inputs while busy, and measures latency.
  task automatic exec_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output int lat, output int busy_cyc, output bit got_wb);
    @(negedge i_clk);
    typ = t; op1 = a; op2 = b; rd = r;
    lat = 0; busy_cyc = 0; got_wb = 1'b0;
    while (lat < 64) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
      if (o_ex_busy) busy_cyc++;
      if (o_wb_en) got_wb = 1'b1;
      if (o_wb_en || !o_ex_busy) begin
        typ = OP_NOP;
        break;
      end
      typ = 4'($urandom_range(1, 10)); op1 = $urandom; op2 = $urandom; rd = 5'($urandom);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++; if (o_wb_en !== 1'b0) $display("FAIL rst_wb_en: got %b, required 0", o_wb_en); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd0) $display("FAIL rst_wb_rd: got %0d, required 0", o_wb_rd); else n_pass++;
    n_checks++; if (o_wb_data !== 32'd0) $display("FAIL rst_wb_data: got %h, required 0", o_wb_data); else n_pass++;
    n_checks++; if (o_ex_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", o_ex_busy); else n_pass++;
    i_rst  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_alu();
    logic [3:0]  t_tab[8] = '{OP_ADD, OP_SLT, OP_SLTU, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_ADD};
    logic [31:0] a_tab[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                              32'hF0F0F0F0, 32'h12340000, 32'hFFFF0000, 32'hFFFFFFFF};
    logic [31:0] b_tab[8] = '{32'h1, 32'h1, 32'h1, 32'h1,
                              32'hFF00FF00, 32'h00005678, 32'h12345678, 32'h2};
    logic [31:0] d_tab[8] = '{32'h80000000, 32'h1, 32'h0, 32'hFFFFFFFF,
                              32'h0FF00FF0, 32'h12345678, 32'h12340000, 32'h1};
    int lat, busy_cyc;
    bit got_wb;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({5'(i + 5), d_tab[i]});
      exec_op(t_tab[i], a_tab[i], b_tab[i], 5'(i + 5), lat, busy_cyc, got_wb);
      n_checks++; if (!got_wb) $display("FAIL alu_wb[%0d]: got no pulse, required pulse", i); else n_pass++;
      n_checks++; if (lat != 1) $display("FAIL alu_lat[%0d]: got %0d, required 1", i, lat); else n_pass++;
      n_checks++; if (busy_cyc != 0) $display("FAIL alu_busy[%0d]: got %0d, required 0", i, busy_cyc); else n_pass++;
      @(negedge i_clk);
      n_checks++; if (o_wb_en !== 1'b0) $display("FAIL alu_pulse_end[%0d]: got %b, required 0", i, o_wb_en); else n_pass++;
    end
  endtask

  task automatic test_shift();
    logic [3:0]  t_tab[6] = '{OP_SRA, OP_SLL, OP_SLL, OP_SRL, OP_SRA, OP_SLL};
    logic [31:0] a_tab[6] = '{32'h80000000, 32'h1, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hA5A5A5A5};
    logic [31:0] b_tab[6] = '{32'd4, 32'd0, 32'd31, 32'd1, 32'd30, 32'h28};
    logic [31:0] d_tab[6] = '{32'hF8000000, 32'h1, 32'h80000000, 32'h40000000, 32'h1, 32'hA5A5A500};
    logic [4:0]  r_tab[6] = '{5'd3, 5'd2, 5'd4, 5'd13, 5'd14, 5'd15};
    int lat, busy_cyc, el;
    bit got_wb;
    for (int i = 0; i < 6; i++) begin
      el = exp_lat(t_tab[i], b_tab[i]);
      exp_q.push_back({r_tab[i], d_tab[i]});
      exec_op(t_tab[i], a_tab[i], b_tab[i], r_tab[i], lat, busy_cyc, got_wb);
      n_checks++; if (!got_wb) $display("FAIL sh_wb[%0d]: got no pulse, required pulse", i); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL sh_lat[%0d]: got %0d, required %0d", i, lat, el); else n_pass++;
      n_checks++; if (busy_cyc != el - 1) $display("FAIL sh_busy[%0d]: got %0d, required %0d", i, busy_cyc, el - 1); else n_pass++;
      @(negedge i_clk);
      n_checks++; if (o_wb_en !== 1'b0) $display("FAIL sh_pulse_end[%0d]: got %b, required 0", i, o_wb_en); else n_pass++;
    end
  endtask

  task automatic test_no_wb();
    logic [3:0]  t_tab[3] = '{OP_NOP, 4'd12, 4'd15};
    logic [31:0] d_snap;
    logic [4:0]  r_snap;
    int lat, busy_cyc, el;
    bit got_wb;
    exec_op(OP_ADD, 32'd5, 32'd6, 5'd0, lat, busy_cyc, got_wb);
    n_checks++; if (got_wb) $display("FAIL rd0_add_wb: got pulse, required none"); else n_pass++;
    n_checks++; if (lat != 1) $display("FAIL rd0_add_lat: got %0d, required 1", lat); else n_pass++;
    el = exp_lat(OP_SLL, 32'd3);
    exec_op(OP_SLL, 32'h1, 32'd3, 5'd0, lat, busy_cyc, got_wb);
    n_checks++; if (got_wb) $display("FAIL rd0_sll_wb: got pulse, required none"); else n_pass++;
    n_checks++; if (lat != el) $display("FAIL rd0_sll_lat: got %0d, required %0d", lat, el); else n_pass++;
    exp_q.push_back({5'd20, 32'hCAFEF00D});
    exec_op(OP_OR, 32'hCAFE0000, 32'h0000F00D, 5'd20, lat, busy_cyc, got_wb);
    d_snap = 32'hCAFEF00D;
    r_snap = 5'd20;
    for (int i = 0; i < 3; i++) begin
      exec_op(t_tab[i], 32'h1111_1111, 32'h2222_2222, 5'd9, lat, busy_cyc, got_wb);
      @(negedge i_clk);
      n_checks++; if (got_wb) $display("FAIL nop_wb[%0d]: got pulse, required none", i); else n_pass++;
      n_checks++; if (o_wb_data !== d_snap) $display("FAIL nop_data[%0d]: got %h, required %h", i, o_wb_data, d_snap); else n_pass++;
      n_checks++; if (o_wb_rd !== r_snap) $display("FAIL nop_rd[%0d]: got %0d, required %0d", i, o_wb_rd, r_snap); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, busy_cyc, pulses;
    bit got_wb;
    if (FAST) exp_q.push_back({5'd7, 32'h003FFFC0});
    @(negedge i_clk);
    typ = OP_SRL; op1 = 32'hFFFF0000; op2 = 32'd10; rd = 5'd7;
    @(posedge i_clk);
    @(negedge i_clk);
    typ = OP_NOP;
    @(posedge i_clk);
    @(negedge i_clk);
    n_checks++; if (o_ex_busy !== !FAST) $display("FAIL mid_busy: got %b, required %b", o_ex_busy, !FAST); else n_pass++;
    i_rst = 1'b1;
    #1;
    n_checks++; if (o_ex_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", o_ex_busy); else n_pass++;
    n_checks++; if (o_wb_en !== 1'b0) $display("FAIL mid_rst_wb_en: got %b, required 0", o_wb_en); else n_pass++;
    n_checks++; if (o_wb_data !== 32'd0) $display("FAIL mid_rst_data: got %h, required 0", o_wb_data); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd0) $display("FAIL mid_rst_rd: got %0d, required 0", o_wb_rd); else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    pulses = 0;
    repeat (14) begin
      @(negedge i_clk);
      if (o_wb_en) pulses++;
    end
    n_checks++; if (pulses != 0) $display("FAIL mid_no_wb: got %0d pulses, required 0", pulses); else n_pass++;
    exp_q.push_back({5'd1, 32'd5});
    exec_op(OP_ADD, 32'd2, 32'd3, 5'd1, lat, busy_cyc, got_wb);
    n_checks++; if (!got_wb || lat != 1) $display("FAIL mid_add: got wb=%0d lat=%0d, required wb=1 lat=1", got_wb, lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int waited;
    exp_q.push_back({5'd4, 32'hC});
    @(negedge i_clk);
    typ = OP_SLL; op1 = 32'd3; op2 = 32'd2; rd = 5'd4;
    @(posedge i_clk);
    waited = 1;
    @(negedge i_clk);
    typ = OP_NOP;
    while (!o_wb_en && waited < 20) begin
      @(posedge i_clk);
      waited++;
      @(negedge i_clk);
    end
    n_checks++; if (waited != exp_lat(OP_SLL, 32'd2)) $display("FAIL b2b_shift_lat: got %0d, required %0d", waited, exp_lat(OP_SLL, 32'd2)); else n_pass++;
    typ = OP_ADD; op1 = 32'd10; op2 = 32'd20; rd = 5'd6;
    exp_q.push_back({5'd6, 32'd30});
    @(posedge i_clk);
    @(negedge i_clk);
    typ = OP_NOP;
    n_checks++; if (o_wb_en !== 1'b1) $display("FAIL b2b_add_wb: got %b, required 1", o_wb_en); else n_pass++;
    n_checks++; if (o_ex_busy !== 1'b0) $display("FAIL b2b_busy: got %b, required 0", o_ex_busy); else n_pass++;
    @(negedge i_clk);
    n_checks++; if (o_wb_en !== 1'b0) $display("FAIL b2b_pulse_end: got %b, required 0", o_wb_en); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  t;
    logic [31:0] a, b;
    logic [4:0]  r;
    int lat, busy_cyc, el;
    bit got_wb, exp_wb;
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (t >= OP_SLL && t <= OP_SRA) b[4:0] = 5'($urandom_range(0, 6));
      r = 5'($urandom_range(0, 31));
      el = exp_lat(t, b);
      exp_wb = (t >= OP_ADD && t <= OP_SRA) && (r != 5'd0);
      if (exp_wb) exp_q.push_back({r, model(t, a, b)});
      exec_op(t, a, b, r, lat, busy_cyc, got_wb);
      n_checks++; if (got_wb != exp_wb) $display("FAIL rnd_wb[%0d]: got %0d, required %0d (type %0d rd %0d)", i, got_wb, exp_wb, t, r); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL rnd_lat[%0d]: got %0d, required %0d (type %0d)", i, lat, el, t); else n_pass++;
      n_checks++; if (busy_cyc != el - 1) $display("FAIL rnd_busy[%0d]: got %0d, required %0d", i, busy_cyc, el - 1); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift();
    test_no_wb();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending write-backs, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nnrv_ex.md
Name: nnrv_ex

Overview:
- Execute stage, directly downstream of the decode stage.
- Consumes the registered operand pair, op-type code and destination index that decode produces.
- Computes the integer ALU result and presents a one-cycle register-file write-back pulse.
- Shifts run iteratively (1 bit/cycle); a busy output stalls decode/fetch while a shift is in flight.

Parameters:
- XLEN, 32, datapath width.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_exec_op1  input  XLEN  operand 1 (rs1 value).
- i_exec_op2  input  XLEN  operand 2 (rs2 value or immediate); shift amount = op2[SHAMT_W-1:0].
- i_exec_type  input  4  op code: 0 NOP, 1 ADD, 2 SUB, 3 SLT, 4 SLTU, 5 XOR, 6 OR, 7 AND, 8 SLL, 9 SRL, 10 SRA.
- i_exec_rd  input  5  destination register index.
- o_ex_busy  output  1  stall: upstream must hold its outputs stable while high.
- o_wb_en  output  1  write-back strobe, one-cycle pulse.
- o_wb_rd  output  5  write-back register index.
- o_wb_data  output  XLEN  write-back data.

Behaviour:
- Reset: all outputs are 0, state = IDLE, internal accumulator and counter are 0. Reset mid-shift aborts the operation with no write-back.
- States:
  - IDLE accepts inputs on every rising edge.
  - SHIFT ignores inputs. o_ex_busy = (state == SHIFT) and is registered.
- IDLE, types 1-7: results are registered at the accepting edge, so latency is 1 edge.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is unsigned. Both produce 0 or 1 zero-extended.
  - o_wb_en = 1 for one cycle, o_wb_rd = i_exec_rd.
- IDLE, types 8-10 with shamt == 0: complete like an ALU op, o_wb_data = op1, 1 edge.
- IDLE, types 8-10 with shamt N > 0:
  - At the accepting edge: acc <= op1, cnt <= N, rd and direction are latched, state <= SHIFT, o_wb_en <= 0.
  - Each SHIFT edge: acc shifts by 1 (SLL fills 0, SRL fills 0, SRA fills acc[XLEN-1]) and cnt decrements.
  - On the edge where cnt == 1: o_wb_data <= the final shifted value, o_wb_en <= 1, state <= IDLE.
  - Total latency is N+1 edges. o_ex_busy is high for exactly N cycles.
- NOP (0) and undefined codes 11-15: o_wb_en <= 0; o_wb_data and o_wb_rd hold their previous values; no state change.
- rd == 0: the operation executes normally but o_wb_en is forced to 0.
- o_wb_en is low in every cycle without a completing op; never two pulses for one op.
- Back-to-back: the edge that completes a shift returns to IDLE. The next op is accepted on the following edge, the first edge with busy low.

Optional Feature:
- NNRV_EX_FAST_SHIFT_EN defined: SLL/SRL/SRA use a combinational barrel shifter with 1-edge latency. The SHIFT state is never entered and o_ex_busy is tied to 0.
- NNRV_EX_FAST_SHIFT_EN undefined: iterative shifter as specified above.
- Functional results are identical in both builds; only latency and busy differ.

Decomposition:
- Shared package nnrv_pkg holds the op-type constants (OP_NOP..OP_SRA, 4-bit), the XLEN default and the FSM state encoding (IDLE, SHIFT). The decode stage migrates to the same constants.
- One sub-module: nnrv_ex_shifter, which contains the iterative/barrel shifter (acc, cnt, done) and the NNRV_EX_FAST_SHIFT_EN selection.
- The ALU compare/logic stays inline in nnrv_ex.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, rd=5 → next edge o_wb_en=1, rd=5, data=0x80000000; the following cycle o_wb_en=0.
- SLT 0xFFFFFFFF vs 0x00000001 → 1; SLTU with the same operands → 0; SUB 0 − 1 → 0xFFFFFFFF.
- SRA op1=0x80000000, op2=4, rd=3 → busy high 4 cycles, wb at edge 5 with data 0xF8000000. The same case under NNRV_EX_FAST_SHIFT_EN → wb at edge 1, busy never high.
- SLL op1=1, shamt 0 → 1-edge result 0x1. SLL shamt 31 → 0x80000000 after 32 edges. Inputs changed during busy are ignored.
- ADD with rd=0 → o_wb_en stays 0. Type 12 → no wb, o_wb_data unchanged.
- Assert i_rst at busy cycle 2 of SRL shamt 10 → outputs 0 immediately, no wb pulse after release, next ADD 2+3=5 completes in 1 edge.
